// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide memory controller.
// Holds the FSM state type, request length codes and the length-to-byte-count helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIfRd,
        StMmRd,
        StMmWr
    } state_e;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    localparam logic [1:0] IO_HI = 2'b11;

    // The illegal code 3 is treated as a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            LEN_W:   n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Request arbitration for the memory controller: the MEM stage wins over fetch,
// and a fetch request that arrives together with a flush is dropped.
module mem_ctrl_arb (
    input  logic if_req_i,
    input  logic if_flush_i,
    input  logic mm_req_i,
    output logic grant_if_o,
    output logic grant_mm_o
);

    always_comb begin
        grant_mm_o = mm_req_i;
        grant_if_o = if_req_i & ~if_flush_i & ~mm_req_i;
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide external memory sequencer shared by instruction fetch and the MEM stage.
// Build option MEM_CTRL_IO_WAIT_EN: throttle I/O-space stores on io_buffer_full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_HI  = mem_ctrl_pkg::IO_HI
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mm_req,
    input  logic              mm_we,
    input  logic [1:0]        mm_len,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic [31:0]       mm_wdata,
    output logic              mm_done,
    output logic [31:0]       mm_rdata,
    output logic              stall_req,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

`ifdef MEM_CTRL_IO_WAIT_EN
    localparam bit IoWaitEn = 1'b1;
`else
    localparam bit IoWaitEn = 1'b0;
`endif

    state_e              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [1:0]          last_q;
    logic [1:0]          cnt_q;
    logic                issued_q;
    logic [23:0]         buf_q;
    logic [31:0]         wdata_q;
    logic [ADDR_W-1:0]   mem_a_q;
    logic [7:0]          mem_dout_q;
    logic                mem_wr_q;
    logic                if_done_q;
    logic                mm_done_q;
    logic [31:0]         if_inst_q;
    logic [31:0]         mm_rdata_q;

    logic                if_pend;
    logic                mm_pend;
    logic                grant_if;
    logic                grant_mm;
    logic [1:0]          cnt_nxt;
    logic [ADDR_W-1:0]   a_nxt;
    logic                hold_acc;
    logic                hold_cur;
    logic                hold_nxt;
    logic                gap_cur;
    logic [31:0]         rd_word;

    // A requester whose done pulse is out this cycle must not be re-granted.
    assign if_pend = if_req & ~if_done_q;
    assign mm_pend = mm_req & ~mm_done_q;

    mem_ctrl_arb u_arb (
        .if_req_i   (if_pend),
        .if_flush_i (if_flush),
        .mm_req_i   (mm_pend),
        .grant_if_o (grant_if),
        .grant_mm_o (grant_mm)
    );

    assign cnt_nxt = cnt_q + 2'd1;
    assign a_nxt   = base_q + ADDR_W'(cnt_nxt);

    // I/O bytes wait for buffer space and leave a gap behind them for the full flag to catch up.
    assign hold_acc = IoWaitEn & io_buffer_full & mm_we & (mm_addr[17:16] == IO_HI);
    assign hold_cur = IoWaitEn & io_buffer_full & (mem_a_q[17:16] == IO_HI);
    assign hold_nxt = IoWaitEn & io_buffer_full & (a_nxt[17:16] == IO_HI);
    assign gap_cur  = IoWaitEn & (mem_a_q[17:16] == IO_HI);

    always_comb begin
        rd_word = {8'h00, buf_q};
        rd_word[{cnt_q, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            base_q     <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            issued_q   <= 1'b0;
            buf_q      <= '0;
            wdata_q    <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            mm_done_q  <= 1'b0;
            if_inst_q  <= '0;
            mm_rdata_q <= '0;
        end else if (!rdy_in) begin
            mem_wr_q <= 1'b0;
            issued_q <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            mm_done_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    buf_q <= '0;
                    if (grant_mm) begin
                        base_q     <= mm_addr;
                        last_q     <= 2'(len_bytes(mm_len) - 3'd1);
                        wdata_q    <= mm_wdata;
                        mem_a_q    <= mm_addr;
                        mem_dout_q <= mm_wdata[7:0];
                        if (mm_we) begin
                            state_q  <= StMmWr;
                            mem_wr_q <= ~hold_acc;
                            issued_q <= ~hold_acc;
                        end else begin
                            state_q  <= StMmRd;
                            issued_q <= 1'b1;
                        end
                    end else if (grant_if) begin
                        base_q   <= if_addr;
                        last_q   <= 2'd3;
                        mem_a_q  <= if_addr;
                        issued_q <= 1'b1;
                        state_q  <= StIfRd;
                    end
                end
                StIfRd, StMmRd: begin
                    if (state_q == StIfRd && if_flush) begin
                        state_q  <= StIdle;
                        issued_q <= 1'b0;
                    end else if (cnt_q == last_q) begin
                        state_q  <= StIdle;
                        issued_q <= 1'b0;
                        if (state_q == StIfRd) begin
                            if_done_q <= 1'b1;
                            if_inst_q <= rd_word;
                        end else begin
                            mm_done_q  <= 1'b1;
                            mm_rdata_q <= rd_word;
                        end
                    end else begin
                        buf_q    <= rd_word[23:0];
                        cnt_q    <= cnt_nxt;
                        mem_a_q  <= a_nxt;
                        issued_q <= 1'b1;
                    end
                end
                StMmWr: begin
                    if (!issued_q) begin
                        if (!hold_cur) begin
                            mem_wr_q <= 1'b1;
                            issued_q <= 1'b1;
                        end
                    end else if (cnt_q == last_q) begin
                        state_q   <= StIdle;
                        issued_q  <= 1'b0;
                        mm_done_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_nxt;
                        mem_a_q    <= a_nxt;
                        mem_dout_q <= wdata_q[{cnt_nxt, 3'b000} +: 8];
                        if (gap_cur || hold_nxt) begin
                            issued_q <= 1'b0;
                        end else begin
                            mem_wr_q <= 1'b1;
                            issued_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign if_done   = if_done_q;
    assign if_inst   = if_inst_q;
    assign mm_done   = mm_done_q;
    assign mm_rdata  = mm_rdata_q;
    assign stall_req = mm_req & ~mm_done_q;
    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide memory model plus per-scenario tasks that
// queue expected bus beats and results at stimulus time and pop them as the DUT produces them.
module tb_mem_ctrl;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mm_req;
    logic        mm_we;
    logic [1:0]  mm_len;
    logic [31:0] mm_addr;
    logic [31:0] mm_wdata;
    logic        mm_done;
    logic [31:0] mm_rdata;
    logic        stall_req;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
    } bus_t;

    bus_t        exp_bus_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    logic [7:0] ram [0:4095];

    mem_ctrl dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_flush       (if_flush),
        .if_done        (if_done),
        .if_inst        (if_inst),
        .mm_req         (mm_req),
        .mm_we          (mm_we),
        .mm_len         (mm_len),
        .mm_addr        (mm_addr),
        .mm_wdata       (mm_wdata),
        .mm_done        (mm_done),
        .mm_rdata       (mm_rdata),
        .stall_req      (stall_req),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read RAM; contents are reloaded whenever reset is held.
    always @(posedge clk) begin
        if (!rst_in) begin
            ram[12'h000] <= 8'h41;
            ram[12'h040] <= 8'hEF;
            ram[12'h041] <= 8'hBE;
            ram[12'h042] <= 8'hAD;
            ram[12'h043] <= 8'hDE;
            ram[12'h100] <= 8'h13;
            ram[12'h101] <= 8'h05;
            ram[12'h102] <= 8'h10;
            ram[12'h103] <= 8'h00;
        end else if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
        end
    end
    assign mem_din = ram[mem_a[11:0]];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (2) next_cycle();
        n_checks++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got a=%h wr=%b d=%h expected 0/0/0", mem_a, mem_wr, mem_dout);
        end
        n_checks++;
        if (if_done !== 1'b0 || mm_done !== 1'b0 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got if_done=%b mm_done=%b stall=%b expected 0", if_done,
                     mm_done, stall_req);
        end
        n_checks++;
        if (if_inst !== 32'h0 || mm_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got inst=%h rdata=%h expected 0", if_inst, mm_rdata);
        end
        rst_in = 1'b1;
    endtask

    task automatic test_fetch();
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(32'h100 + k);
        exp_data_q.push_back(32'h0010_0513);
        next_cycle();
        if_req  = 1'b1;
        if_addr = 32'h100;
        for (int t = 1; t <= 5; t++) begin
            next_cycle();
            n_checks++;
            if (t <= 4) begin
                logic [31:0] ea;
                ea = exp_addr_q.pop_front();
                if (mem_a !== ea || mem_wr !== 1'b0 || if_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_addr T%0d: got a=%h wr=%b done=%b expected a=%h wr=0 done=0",
                             t, mem_a, mem_wr, if_done, ea);
                end
            end else begin
                logic [31:0] ed;
                ed = exp_data_q.pop_front();
                if (if_done !== 1'b1 || if_inst !== ed || mm_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_done: got done=%b inst=%h mm_done=%b expected 1 %h 0",
                             if_done, if_inst, mm_done, ed);
                end
                if_req = 1'b0;
            end
        end
        next_cycle();
        n_checks++;
        if (if_done !== 1'b0 || if_inst !== 32'h0010_0513) begin
            n_fail++;
            $display("FAIL fetch_hold: got done=%b inst=%h expected 0 00100513", if_done, if_inst);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;
        wd = 32'hAABB_CCDD;
        for (int k = 0; k < 4; k++) exp_bus_q.push_back('{1'b1, 32'h200 + k, wd[8*k +: 8]});
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(32'h100 + k);
        exp_data_q.push_back(32'h0010_0513);
        next_cycle();
        mm_req   = 1'b1;
        mm_we    = 1'b1;
        mm_len   = 2'd2;
        mm_addr  = 32'h200;
        mm_wdata = wd;
        if_req   = 1'b1;
        if_addr  = 32'h100;
        #1;
        n_checks++;
        if (stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_stall_T0: got %b expected 1", stall_req);
        end
        for (int t = 1; t <= 10; t++) begin
            next_cycle();
            n_checks++;
            if (t <= 4) begin
                bus_t eb;
                eb = exp_bus_q.pop_front();
                if (mem_wr !== eb.wr || mem_a !== eb.a || mem_dout !== eb.d || stall_req !== 1'b1 ||
                    mm_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_write T%0d: got wr=%b a=%h d=%h stall=%b expected 1 %h %h 1",
                             t, mem_wr, mem_a, mem_dout, stall_req, eb.a, eb.d);
                end
            end else if (t == 5) begin
                if (mm_done !== 1'b1 || stall_req !== 1'b0 || if_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_mm_done: got done=%b stall=%b if_done=%b expected 1 0 0",
                             mm_done, stall_req, if_done);
                end
                mm_req = 1'b0;
                mm_we  = 1'b0;
            end else if (t <= 9) begin
                logic [31:0] ea;
                ea = exp_addr_q.pop_front();
                if (mem_a !== ea || mem_wr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_fetch_addr T%0d: got a=%h wr=%b expected %h 0", t, mem_a,
                             mem_wr, ea);
                end
            end else begin
                logic [31:0] ed;
                ed = exp_data_q.pop_front();
                if (if_done !== 1'b1 || if_inst !== ed) begin
                    n_fail++;
                    $display("FAIL b2b_fetch_done: got done=%b inst=%h expected 1 %h", if_done,
                             if_inst, ed);
                end
                if_req = 1'b0;
            end
        end
        n_checks++;
        if ({ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]} !== wd) begin
            n_fail++;
            $display("FAIL b2b_ram: got %h%h%h%h expected %h", ram[12'h203], ram[12'h202],
                     ram[12'h201], ram[12'h200], wd);
        end
    endtask

    task automatic test_loads();
        logic [31:0] la [3];
        logic [1:0]  ll [3];
        la = '{32'h202, 32'h30000, 32'h200};
        ll = '{2'd1, 2'd0, 2'd3};
        exp_data_q.push_back(32'h0000_AABB);
        exp_data_q.push_back(32'h0000_0041);
        exp_data_q.push_back(32'hAABB_CCDD);
        for (int i = 0; i < 3; i++) begin
            int n;
            n = (ll[i] == 2'd0) ? 1 : (ll[i] == 2'd1) ? 2 : 4;
            next_cycle();
            mm_req  = 1'b1;
            mm_we   = 1'b0;
            mm_len  = ll[i];
            mm_addr = la[i];
            for (int t = 1; t <= n + 1; t++) begin
                next_cycle();
                n_checks++;
                if (t <= n) begin
                    if (mem_a !== la[i] + t - 1 || mem_wr !== 1'b0 || mm_done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL load%0d_addr T%0d: got a=%h wr=%b done=%b expected %h 0 0",
                                 i, t, mem_a, mem_wr, mm_done, la[i] + t - 1);
                    end
                end else begin
                    logic [31:0] ed;
                    ed = exp_data_q.pop_front();
                    if (mm_done !== 1'b1 || mm_rdata !== ed || if_done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL load%0d_done: got done=%b rdata=%h expected 1 %h", i,
                                 mm_done, mm_rdata, ed);
                    end
                    mm_req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_flush();
        next_cycle();
        if_req  = 1'b1;
        if_addr = 32'h100;
        next_cycle();
        next_cycle();
        if_flush = 1'b1;
        if_req   = 1'b0;
        next_cycle();
        n_checks++;
        if (if_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_done: got %b expected 0", if_done);
        end
        if_flush = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h40;
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(32'h40 + k);
        exp_data_q.push_back(32'hDEAD_BEEF);
        for (int t = 1; t <= 5; t++) begin
            next_cycle();
            n_checks++;
            if (t <= 4) begin
                logic [31:0] ea;
                ea = exp_addr_q.pop_front();
                if (mem_a !== ea || if_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_refetch T%0d: got a=%h done=%b expected %h 0", t, mem_a,
                             if_done, ea);
                end
            end else begin
                logic [31:0] ed;
                ed = exp_data_q.pop_front();
                if (if_done !== 1'b1 || if_inst !== ed) begin
                    n_fail++;
                    $display("FAIL flush_refetch_done: got %b %h expected 1 %h", if_done, if_inst, ed);
                end
                if_req = 1'b0;
            end
        end
        next_cycle();
        if_req   = 1'b1;
        if_flush = 1'b1;
        if_addr  = 32'h100;
        next_cycle();
        if_req   = 1'b0;
        if_flush = 1'b0;
        for (int t = 0; t < 5; t++) begin
            next_cycle();
            n_checks++;
            if (mem_a !== 32'h43 || if_done !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_idle: got a=%h done=%b expected 00000043 0", mem_a, if_done);
            end
        end
    endtask

    task automatic test_rdy_stall();
        logic [31:0] seq [7];
        seq = '{32'h100, 32'h101, 32'h101, 32'h101, 32'h101, 32'h102, 32'h103};
        for (int k = 0; k < 7; k++) exp_addr_q.push_back(seq[k]);
        exp_data_q.push_back(32'h0010_0513);
        next_cycle();
        if_req  = 1'b1;
        if_addr = 32'h100;
        for (int t = 1; t <= 8; t++) begin
            next_cycle();
            n_checks++;
            if (t <= 7) begin
                logic [31:0] ea;
                ea = exp_addr_q.pop_front();
                if (mem_a !== ea || mem_wr !== 1'b0 || if_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rdy_addr T%0d: got a=%h wr=%b done=%b expected %h 0 0", t, mem_a,
                             mem_wr, if_done, ea);
                end
            end else begin
                logic [31:0] ed;
                ed = exp_data_q.pop_front();
                if (if_done !== 1'b1 || if_inst !== ed) begin
                    n_fail++;
                    $display("FAIL rdy_done: got %b %h expected 1 %h", if_done, if_inst, ed);
                end
                if_req = 1'b0;
            end
            if (t == 2) rdy_in = 1'b0;
            if (t == 5) rdy_in = 1'b1;
        end
    endtask

    task automatic test_io_store();
        logic [31:0] sd [2];
        logic [1:0]  sl [2];
        int          fc [2];
        sd = '{32'h0000_005A, 32'h0000_1234};
        sl = '{2'd0, 2'd1};
        fc = '{3, 0};
        for (int i = 0; i < 2; i++) begin
            int nb;
`ifdef MEM_CTRL_IO_WAIT_EN
            if (i == 0) begin
                repeat (3) exp_bus_q.push_back('{1'b0, 32'h0, 8'h0});
                exp_bus_q.push_back('{1'b1, 32'h30000, 8'h5A});
            end else begin
                exp_bus_q.push_back('{1'b1, 32'h30000, 8'h34});
                exp_bus_q.push_back('{1'b0, 32'h0, 8'h0});
                exp_bus_q.push_back('{1'b1, 32'h30001, 8'h12});
            end
`else
            if (i == 0) begin
                exp_bus_q.push_back('{1'b1, 32'h30000, 8'h5A});
            end else begin
                exp_bus_q.push_back('{1'b1, 32'h30000, 8'h34});
                exp_bus_q.push_back('{1'b1, 32'h30001, 8'h12});
            end
`endif
            nb = exp_bus_q.size();
            next_cycle();
            mm_req         = 1'b1;
            mm_we          = 1'b1;
            mm_len         = sl[i];
            mm_addr        = 32'h30000;
            mm_wdata       = sd[i];
            io_buffer_full = (fc[i] > 0);
            for (int t = 1; t <= nb + 1; t++) begin
                next_cycle();
                n_checks++;
                if (t <= nb) begin
                    bus_t eb;
                    eb = exp_bus_q.pop_front();
                    if (mem_wr !== eb.wr || mm_done !== 1'b0 ||
                        (eb.wr && (mem_a !== eb.a || mem_dout !== eb.d))) begin
                        n_fail++;
                        $display("FAIL io%0d_bus T%0d: got wr=%b a=%h d=%h expected wr=%b a=%h d=%h",
                                 i, t, mem_wr, mem_a, mem_dout, eb.wr, eb.a, eb.d);
                    end
                end else begin
                    if (mm_done !== 1'b1 || mem_wr !== 1'b0) begin
                        n_fail++;
                        $display("FAIL io%0d_done: got done=%b wr=%b expected 1 0", i, mm_done,
                                 mem_wr);
                    end
                    mm_req = 1'b0;
                    mm_we  = 1'b0;
                end
                if (t == fc[i]) io_buffer_full = 1'b0;
            end
        end
        n_checks++;
        if (ram[12'h000] !== 8'h34 || ram[12'h001] !== 8'h12) begin
            n_fail++;
            $display("FAIL io_ram: got %h %h expected 34 12", ram[12'h000], ram[12'h001]);
        end
    endtask

    task automatic test_reset_mid_write();
        next_cycle();
        mm_req   = 1'b1;
        mm_we    = 1'b1;
        mm_len   = 2'd2;
        mm_addr  = 32'h210;
        mm_wdata = 32'h1122_3344;
        next_cycle();
        n_checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h210 || mem_dout !== 8'h44) begin
            n_fail++;
            $display("FAIL rstmid_first: got wr=%b a=%h d=%h expected 1 00000210 44", mem_wr,
                     mem_a, mem_dout);
        end
        next_cycle();
        rst_in = 1'b0;
        next_cycle();
        n_checks++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0 || mm_done !== 1'b0 ||
            if_inst !== 32'h0 || mm_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got a=%h wr=%b d=%h done=%b inst=%h rdata=%h expected 0",
                     mem_a, mem_wr, mem_dout, mm_done, if_inst, mm_rdata);
        end
        rst_in = 1'b1;
        mm_req = 1'b0;
        mm_we  = 1'b0;
        for (int t = 0; t < 4; t++) begin
            next_cycle();
            n_checks++;
            if (mm_done !== 1'b0 || mem_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet: got done=%b wr=%b expected 0 0", mm_done, mem_wr);
            end
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_in         = 1'b0;
        rdy_in         = 1'b1;
        if_req         = 1'b0;
        if_addr        = 32'h0;
        if_flush       = 1'b0;
        mm_req         = 1'b0;
        mm_we          = 1'b0;
        mm_len         = 2'd0;
        mm_addr        = 32'h0;
        mm_wdata       = 32'h0;
        io_buffer_full = 1'b0;
        test_reset();
        test_fetch();
        test_back_to_back();
        test_loads();
        test_flush();
        test_rdy_stall();
        test_io_store();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sequences and arbitrates the single byte-wide external memory bus (mem_din/mem_dout/mem_a/mem_wr) between two requesters.
- Requester 1 is instruction fetch, which does 32-bit reads.
- Requester 2 is the MEM stage, which does 1/2/4-byte loads and stores.
- Each request is split into byte transactions and the result is reassembled little-endian.
- Sits between pc_reg/if_id and the mem stage at the cpu top level; also raises the stall request that ctrl consumes.

Parameters:
- ADDR_W, 32, address width of requester and bus addresses.
- IO_HI, 2'b11, value of addr[17:16] that marks I/O space.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, synchronous, active-low (0 = reset).
- rdy_in  in  1  global ready; all state freezes while low.
- if_req  in  1  fetch request; held until if_done or if_flush.
- if_addr  in  32  fetch address, word-aligned.
- if_flush  in  1  abort any fetch (branch taken).
- if_done  out  1  one-cycle pulse; if_inst is valid in the same cycle.
- if_inst  out  32  fetched instruction.
- mm_req  in  1  MEM-stage request; held until mm_done.
- mm_we  in  1  1 = store, 0 = load.
- mm_len  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal and treated as 4.
- mm_addr  in  32  byte address.
- mm_wdata  in  32  store data; low bytes are used.
- mm_done  out  1  one-cycle completion pulse.
- mm_rdata  out  32  load data, zero-extended.
- stall_req  out  1  high while mm_req is pending and not yet done.
- mem_din  in  8  bus read data.
- mem_dout  out  8  bus write data.
- mem_a  out  32  bus address.
- mem_wr  out  1  bus write strobe.
- io_buffer_full  in  1  UART tx buffer full.

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - state=IDLE; mem_a=0, mem_dout=0, mem_wr=0.
  - if_done=0, mm_done=0, if_inst=0, mm_rdata=0, stall_req=0.
  - Byte counter=0, byte-issued flag=0.
  - Reset mid-transfer abandons the transfer; no done pulse.
- rdy_in=0:
  - Every register holds, except mem_wr, which is forced to 0.
  - The issued flag clears, so the byte whose address was last presented is re-presented after resume and any return data is discarded.
- States: IDLE, IF_RD, MM_RD, MM_WR.
- IDLE arbitration:
  - mm_req has priority over if_req.
  - A request seen in cycle T0 latches address, length and data.
  - Bus outputs for byte 0 are registered and appear in T1.
  - If no request is pending: mem_a holds its value and mem_wr=0.
- Read sequencing (IF_RD, MM_RD), n bytes:
  - Byte k address is presented in T(1+k).
  - mem_din is captured in T(2+k) into byte lane k.
  - Done pulses in T(n+1) with the full data, so a fetch completes 5 cycles after acceptance.
  - State returns to IDLE in the done cycle; a new request can be accepted in that same cycle.
  - Addresses are base+k, 32-bit wrap.
- Write sequencing (MM_WR):
  - Byte k: mem_a=base+k, mem_dout=wdata[8k+7:8k], mem_wr=1 in T(1+k).
  - mm_done pulses in T(n+1).
- if_flush:
  - In IF_RD: the fetch is aborted, state goes to IDLE next cycle, and if_done is never pulsed for it.
  - In IDLE in the same cycle as if_req: the request is ignored.
  - MM transfers are never aborted.
- stall_req = mm_req & ~mm_done, combinational.
- Outputs for the non-granted requester stay low.
- mm_req and if_req in the same IDLE cycle: MM is served first; IF is accepted in the cycle MM's done pulses.
- Outputs (rdata/inst) hold their last value between done pulses.

Optional Feature:
- Macro: MEM_CTRL_IO_WAIT_EN.
- Defined: in MM_WR, a byte whose address has addr[17:16]==IO_HI is not issued while io_buffer_full=1.
  - mem_wr stays 0 and the counter holds until io_buffer_full=0.
  - After each I/O byte write, one idle cycle is inserted (mem_wr=0) to cover the one-cycle lag of io_buffer_full.
- Undefined: io_buffer_full is ignored and I/O writes proceed like RAM writes.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - State enum (IDLE/IF_RD/MM_RD/MM_WR).
  - Length codes LEN_B=0, LEN_H=1, LEN_W=2.
  - IO_HI constant.
  - Helper function mapping length code to byte count (1/2/4).
- One sub-module, mem_ctrl_arb: combinational priority/flush grant logic taking if_req, if_flush, mm_req and returning the grant.

Test Plan:
- if_req, if_addr=0x100, memory bytes 0x13,0x05,0x10,0x00 -> mem_a 0x100..0x103 in T1..T4; if_done in T5 with if_inst=0x00100513.
- mm_req and if_req asserted together; mm store len=2, addr=0x200, wdata=0xAABBCCDD -> mem_wr=1 with (0x200,DD),(0x201,CC),(0x202,BB),(0x203,AA) in T1..T4; mm_done in T5; fetch starts in the same cycle; stall_req high T0..T4.
- mm load len=0, addr=0x30000, mem_din=0x41 -> mm_done in T2 with mm_rdata=0x00000041.
- if_flush asserted in T2 of a fetch -> no if_done; state IDLE in T3; a new if_req to 0x40 completes normally.
- rdy_in low in T2..T4 of a 4-byte read -> mem_wr stays 0; byte 1 re-presented after resume; correct data; done delayed exactly 3 cycles. rst_in=0 mid-write -> all outputs 0 the next cycle, no mm_done.
- MEM_CTRL_IO_WAIT_EN defined, store len=0 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr held 0 for 3 cycles, then one write of 0x30000, mm_done the next cycle.
